// File: rtl/game_ctrl.sv
// Game-flow controller: tracks state, level and lives, and checks enemy missiles against the ship once per frame.
// Latency: a missile compare is registered one cycle, then acted on at the next frame tick; all outputs are registered.
// Backpressure: none; every input is sampled each pclk cycle and level_done pulses are latched until consumed.
//
// Ports:
//   pclk, rst            pixel clock and synchronous active-high reset
//   vsync_in             frame timing; rising edge = frame tick
//   start_button         raw asynchronous button; synchronised, then edge-detected
//   level_done           one-cycle pulse from the enemies stage
//   ship_x, ship_y       ship hitbox top-left corner
//   en_x/y_missile       packed missile coordinates, channel k at [11k+10:11k]
//   level_out, lives_out current level (1..MAX_LEVEL) and remaining lives
//   state_out            IDLE=0 PLAY=1 HIT=2 LEVEL_UP=3 GAME_OVER=4 WIN=5
//   freeze_out           1 = movement and firing halted
//   ship_hit             one-cycle pulse on each registered hit
// Build option: define GAME_CTRL_GODMODE_EN so that hits still flash (HIT) but never cost a life.
module game_ctrl #(
    parameter int N_MISSILES    = 3,
    parameter int MAX_LEVEL     = 4,
    parameter int LIVES         = 3,
    parameter int SHIP_W        = 64,
    parameter int SHIP_H        = 48,
    parameter int INVULN_FRAMES = 60,
    parameter int PAUSE_FRAMES  = 90,
    parameter int SCREEN_H      = 768
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    vsync_in,
    input  logic                    start_button,
    input  logic                    level_done,
    input  logic [10:0]             ship_x,
    input  logic [10:0]             ship_y,
    input  logic [11*N_MISSILES-1:0] en_x_missile,
    input  logic [11*N_MISSILES-1:0] en_y_missile,
    output logic [3:0]              level_out,
    output logic [3:0]              lives_out,
    output logic [2:0]              state_out,
    output logic                    freeze_out,
    output logic                    ship_hit
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam int CNT_MAX = (INVULN_FRAMES > PAUSE_FRAMES) ? INVULN_FRAMES : PAUSE_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [3:0]       LEVEL_MAX   = 4'(MAX_LEVEL);
    localparam logic [3:0]       LIVES_INIT  = 4'(LIVES);
    localparam logic [11:0]      SHIP_W_M1   = 12'(SHIP_W - 1);
    localparam logic [11:0]      SHIP_H_M1   = 12'(SHIP_H - 1);
    localparam logic [11:0]      Y_LIMIT     = 12'(SCREEN_H);

    state_t           state, state_nxt;
    logic [3:0]       level_nxt, lives_nxt;
    logic [CNT_W-1:0] frame_cnt, cnt_nxt;
    logic             done_pend, done_nxt;
    logic             hit_nxt, freeze_nxt;

    logic             start_s1, start_s2, start_s3;
    logic             vsync_q;
    logic             start_edge, frame_tick;
    logic             hit_any_q, hit_any_c;

    // Bounds are 12 bits wide so ship_x + SHIP_W - 1 cannot wrap at the screen edge.
    logic [11:0]      x_lo, x_hi, y_lo, y_hi, mx, my;

    assign x_lo = {1'b0, ship_x};
    assign y_lo = {1'b0, ship_y};
    assign x_hi = x_lo + SHIP_W_M1;
    assign y_hi = y_lo + SHIP_H_M1;

    assign start_edge = start_s2 & ~start_s3;
    assign frame_tick = vsync_in & ~vsync_q;
    assign state_out  = state;

    always_comb begin
        hit_any_c = 1'b0;
        mx        = '0;
        my        = '0;
        for (int k = 0; k < N_MISSILES; k++) begin
            mx = {1'b0, en_x_missile[11*k +: 11]};
            my = {1'b0, en_y_missile[11*k +: 11]};
            // y at or below the screen bottom marks a parked (inactive) channel.
            if ((my < Y_LIMIT) && (mx >= x_lo) && (mx <= x_hi) &&
                (my >= y_lo) && (my <= y_hi)) begin
                hit_any_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level_out;
        lives_nxt = lives_out;
        cnt_nxt   = frame_cnt;
        done_nxt  = done_pend;
        hit_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                done_nxt = done_pend | level_done;
                if (frame_tick) begin
                    if (hit_any_q) begin
                        hit_nxt = 1'b1;
`ifdef GAME_CTRL_GODMODE_EN
                        cnt_nxt   = '0;
                        state_nxt = ST_HIT;
`else
                        if (lives_out <= 4'd1) begin
                            lives_nxt = 4'd0;
                            done_nxt  = 1'b0;
                            state_nxt = ST_GAME_OVER;
                        end else begin
                            lives_nxt = lives_out - 4'd1;
                            cnt_nxt   = '0;
                            state_nxt = ST_HIT;
                        end
`endif
                    end else if (done_pend) begin
                        // A fresh level_done arriving in this very cycle stays pending.
                        done_nxt = level_done;
                        if (level_out >= LEVEL_MAX) begin
                            state_nxt = ST_WIN;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = ST_LEVEL_UP;
                        end
                    end
                end
            end
            ST_HIT: begin
                done_nxt = done_pend | level_done;
                if (frame_tick) begin
                    if (frame_cnt == INVULN_LAST) state_nxt = ST_PLAY;
                    else                          cnt_nxt   = frame_cnt + 1'b1;
                end
            end
            ST_LEVEL_UP: begin
                if (frame_tick) begin
                    if (frame_cnt == PAUSE_LAST) begin
                        if (level_out < LEVEL_MAX) level_nxt = level_out + 4'd1;
                        state_nxt = ST_PLAY;
                    end else begin
                        cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start_edge) begin
                    level_nxt = 4'd1;
                    lives_nxt = LIVES_INIT;
                    done_nxt  = 1'b0;
                    state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        freeze_nxt = !((state_nxt == ST_PLAY) || (state_nxt == ST_HIT));
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_s3   <= 1'b0;
            vsync_q    <= 1'b0;
            hit_any_q  <= 1'b0;
            state      <= ST_IDLE;
            level_out  <= 4'd1;
            lives_out  <= LIVES_INIT;
            frame_cnt  <= '0;
            done_pend  <= 1'b0;
            ship_hit   <= 1'b0;
            freeze_out <= 1'b1;
        end else begin
            start_s1   <= start_button;
            start_s2   <= start_s1;
            start_s3   <= start_s2;
            vsync_q    <= vsync_in;
            hit_any_q  <= hit_any_c;
            state      <= state_nxt;
            level_out  <= level_nxt;
            lives_out  <= lives_nxt;
            frame_cnt  <= cnt_nxt;
            done_pend  <= done_nxt;
            ship_hit   <= hit_nxt;
            freeze_out <= freeze_nxt;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters.
// Inputs are driven and outputs sampled on the falling pclk edge.
// Expectations follow GAME_CTRL_GODMODE_EN when the bench is built with it.
module tb_game_ctrl;

    localparam int N = 3;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic            vsync_in = 1'b0;
    logic            start_button = 1'b0;
    logic            level_done = 1'b0;
    logic [10:0]     ship_x = 11'd480;
    logic [10:0]     ship_y = 11'd700;
    logic [11*N-1:0] en_x_missile = '0;
    logic [11*N-1:0] en_y_missile = '0;
    logic [3:0]      level_out, lives_out;
    logic [2:0]      state_out;
    logic            freeze_out, ship_hit;

    int n_vec = 0;
    int n_err = 0;
    int hit_cnt = 0;
    int h0;
    int exp_lives;

    game_ctrl dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .start_button (start_button),
        .level_done   (level_done),
        .ship_x       (ship_x),
        .ship_y       (ship_y),
        .en_x_missile (en_x_missile),
        .en_y_missile (en_y_missile),
        .level_out    (level_out),
        .lives_out    (lives_out),
        .state_out    (state_out),
        .freeze_out   (freeze_out),
        .ship_hit     (ship_hit)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (ship_hit) hit_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_missile(input int k, input int x, input int y);
        en_x_missile[11*k +: 11] = 11'(x);
        en_y_missile[11*k +: 11] = 11'(y);
    endtask

    task automatic park_all();
        for (int k = 0; k < N; k++) set_missile(k, 0, 768);
    endtask

    task automatic frame();
        @(negedge pclk) vsync_in = 1'b1;
        repeat (2) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic press_start();
        @(negedge pclk) start_button = 1'b1;
        repeat (4) @(negedge pclk);
        start_button = 1'b0;
        idle(3);
    endtask

    task automatic pulse_done();
        @(negedge pclk) level_done = 1'b1;
        @(negedge pclk) level_done = 1'b0;
        idle(1);
    endtask

    task automatic lose_life(input string tag);
        idle(2);
        h0 = hit_cnt;
        frame();
`ifndef GAME_CTRL_GODMODE_EN
        exp_lives = exp_lives - 1;
`endif
        chk({tag, "_pulse"}, hit_cnt, h0 + 1);
        chk({tag, "_lives"}, lives_out, exp_lives);
        chk({tag, "_state"}, state_out, 2);
        chk({tag, "_freeze"}, freeze_out, 0);
        frames(59);
        chk({tag, "_inv_state"}, state_out, 2);
        chk({tag, "_inv_lives"}, lives_out, exp_lives);
        chk({tag, "_inv_pulses"}, hit_cnt, h0 + 1);
        frame();
        chk({tag, "_back_play"}, state_out, 1);
        park_all();
        idle(2);
    endtask

    initial begin
        park_all();
        exp_lives = 3;

        // Reset and first start
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst_state", state_out, 0);
        chk("rst_level", level_out, 1);
        chk("rst_lives", lives_out, 3);
        chk("rst_freeze", freeze_out, 1);
        chk("rst_hit", ship_hit, 0);
        frame();
        chk("idle_ignores_frame", state_out, 0);
        @(negedge pclk) start_button = 1'b1;
        repeat (4) @(negedge pclk);
        chk("start_state", state_out, 1);
        chk("start_freeze", freeze_out, 0);
        start_button = 1'b0;
        idle(3);

        // Level progression up to WIN
        for (int lv = 1; lv < 4; lv++) begin
            pulse_done();
            frame();
            chk("lvup_state", state_out, 3);
            chk("lvup_freeze", freeze_out, 1);
            frames(89);
            chk("lvup_hold_state", state_out, 3);
            chk("lvup_hold_level", level_out, lv);
            frame();
            chk("lvup_done_state", state_out, 1);
            chk("lvup_done_level", level_out, lv + 1);
        end
        pulse_done();
        frame();
        chk("win_state", state_out, 5);
        chk("win_level", level_out, 4);
        chk("win_freeze", freeze_out, 1);
        frames(2);
        chk("win_hold", state_out, 5);
        press_start();
        chk("win_restart_state", state_out, 1);
        chk("win_restart_level", level_out, 1);
        chk("win_restart_lives", lives_out, 3);

        // Hit on a middle channel, inside the box
        set_missile(1, 500, 710);
        lose_life("hit1");

        // Near misses: one past right edge, SCREEN_H inside the box, one before left edge
        ship_y = 11'd740;
        set_missile(0, 544, 750);
        set_missile(1, 500, 768);
        set_missile(2, 479, 750);
        idle(2);
        h0 = hit_cnt;
        frames(10);
        chk("miss_pulses", hit_cnt, h0);
        chk("miss_lives", lives_out, exp_lives);
        chk("miss_state", state_out, 1);
        park_all();
        ship_y = 11'd700;

        // Bottom-right inclusive corner hits
        set_missile(2, 543, 747);
        lose_life("hit_corner");

        // Hit and pending level_done in the same frame, top-left corner
        pulse_done();
        set_missile(0, 480, 700);
        idle(2);
        h0 = hit_cnt;
        frame();
        park_all();
        chk("last_pulse", hit_cnt, h0 + 1);
`ifdef GAME_CTRL_GODMODE_EN
        chk("god_state", state_out, 2);
        chk("god_lives", lives_out, 3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        press_start();
`else
        chk("over_state", state_out, 4);
        chk("over_lives", lives_out, 0);
        chk("over_freeze", freeze_out, 1);
        frames(2);
        chk("over_hold_lives", lives_out, 0);
        press_start();
        chk("over_restart_state", state_out, 1);
        chk("over_restart_level", level_out, 1);
        chk("over_restart_lives", lives_out, 3);
`endif
        frame();
        chk("done_pend_cleared", state_out, 1);

        // start is ignored while playing
        press_start();
        chk("start_in_play", state_out, 1);

        // Reach level 2, then reset with a pending level_done and a missile in the box
        pulse_done();
        frame();
        frames(90);
        chk("pre_rst_level", level_out, 2);
        pulse_done();
        set_missile(0, 500, 710);
        idle(2);
        @(negedge pclk) rst = 1'b1;
        @(negedge pclk) rst = 1'b0;
        chk("midrst_state", state_out, 0);
        chk("midrst_level", level_out, 1);
        chk("midrst_lives", lives_out, 3);
        chk("midrst_freeze", freeze_out, 1);
        park_all();
        press_start();
        h0 = hit_cnt;
        frame();
        chk("midrst_discard_state", state_out, 1);
        chk("midrst_discard_hit", hit_cnt, h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
